// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU/extend/branch
// codes and the control bundles carried through ID/EX, EX/MEM and MEM/WB.
package ctrl_pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SLT = 3'd5
   } aluop_t;

   typedef enum logic [1:0] {
      EXT_ZERO   = 2'd0,
      EXT_SIGNED = 2'd1,
      EXT_LUI    = 2'd2
   } extop_t;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EQ   = 2'd1,
      BR_NE   = 2'd2
   } branch_t;

   typedef struct packed {
      aluop_t  aluop;
      logic    alusrc;
      extop_t  extop;
      branch_t branch;
      logic    jump;
      logic    memread;
      logic    memwrite;
      logic    regwrite;
      logic    memtoreg;
      logic    link;
      logic    illegal;
   } ctrl_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
      logic link;
   } mem_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic link;
   } wb_ctrl_t;

   localparam ctrl_t BUBBLE = '{
      aluop:    ALU_ADD,
      alusrc:   1'b0,
      extop:    EXT_ZERO,
      branch:   BR_NONE,
      jump:     1'b0,
      memread:  1'b0,
      memwrite: 1'b0,
      regwrite: 1'b0,
      memtoreg: 1'b0,
      link:     1'b0,
      illegal:  1'b0
   };

   function automatic ctrl_t illegal_bundle();
      ctrl_t c;
      c = BUBBLE;
      c.illegal = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Instruction-side inputs and per-stage control outputs of ctrl_pipe.
interface ctrl_pipe_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [31:0]       ins_id;
   logic              ins_valid;
   logic              flush;
   logic              ext_stall;
   logic              id_stall;
   logic [2:0]        ex_aluop;
   logic              ex_alusrc;
   logic [1:0]        ex_extop;
   logic [1:0]        ex_branch;
   logic              ex_jump;
   logic              ex_illegal;
   logic [REG_AW-1:0] ex_dst;
   logic [REG_AW-1:0] mem_dst;
   logic [REG_AW-1:0] wb_dst;
   logic              mem_memwrite;
   logic              mem_memread;
   logic              wb_regwrite;
   logic              wb_memtoreg;
   logic              wb_link;
   logic [CNT_W-1:0]  bubble_cnt;

   modport slave (
      input  ins_id, ins_valid, flush, ext_stall,
      output id_stall, ex_aluop, ex_alusrc, ex_extop, ex_branch, ex_jump,
             ex_illegal, ex_dst, mem_dst, wb_dst, mem_memwrite, mem_memread,
             wb_regwrite, wb_memtoreg, wb_link, bubble_cnt
   );

   modport master (
      output ins_id, ins_valid, flush, ext_stall,
      input  id_stall, ex_aluop, ex_alusrc, ex_extop, ex_branch, ex_jump,
             ex_illegal, ex_dst, mem_dst, wb_dst, mem_memwrite, mem_memread,
             wb_regwrite, wb_memtoreg, wb_link, bubble_cnt
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: control bundle, destination register
// and which source registers the instruction actually reads.
module ctrl_decode
   import ctrl_pipe_pkg::*;
#(
   parameter int EXT_ISA = 1,
   parameter int REG_AW  = 5
) (
   input  logic [31:0]       ins,
   output ctrl_t             ctrl,
   output logic [REG_AW-1:0] dst,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic              uses_rs,
   output logic              uses_rt
);
   logic [5:0]        opcode_s;
   logic [5:0]        funct_s;
   logic [REG_AW-1:0] rd_s;
   logic              legal_s;
   logic              ext_s;
   logic              unused_shamt;

   assign opcode_s     = ins[31:26];
   assign funct_s      = ins[5:0];
   assign rs           = REG_AW'(ins[25:21]);
   assign rt           = REG_AW'(ins[20:16]);
   assign rd_s         = REG_AW'(ins[15:11]);
   assign ext_s        = (EXT_ISA != 0);
   assign unused_shamt = ^ins[10:6];

   // Opcode/funct decode; unknown or disabled encodings collapse to an illegal bubble
   always_comb begin
      ctrl    = BUBBLE;
      dst     = {REG_AW{1'b0}};
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      legal_s = 1'b1;
      case (opcode_s)
         OP_RTYPE: begin
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
            ctrl.regwrite = 1'b1;
            dst           = rd_s;
            case (funct_s)
               FN_ADD:  ctrl.aluop = ALU_ADD;
               FN_SUB:  begin
                  ctrl.aluop = ALU_SUB;
                  legal_s    = ext_s;
               end
               FN_AND:  ctrl.aluop = ALU_AND;
               FN_OR:   ctrl.aluop = ALU_OR;
               FN_NOR:  ctrl.aluop = ALU_NOR;
               FN_SLT:  ctrl.aluop = ALU_SLT;
               default: legal_s = 1'b0;
            endcase
         end
         OP_LW: begin
            uses_rs       = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.extop    = EXT_SIGNED;
            ctrl.memread  = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
            dst           = rt;
         end
         OP_SW: begin
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.extop    = EXT_SIGNED;
            ctrl.memwrite = 1'b1;
         end
         OP_BEQ: begin
            uses_rs     = 1'b1;
            uses_rt     = 1'b1;
            ctrl.aluop  = ALU_SUB;
            ctrl.branch = BR_EQ;
         end
         OP_BNE: begin
            uses_rs     = 1'b1;
            uses_rt     = 1'b1;
            ctrl.aluop  = ALU_SUB;
            ctrl.branch = BR_NE;
            legal_s     = ext_s;
         end
         OP_J: ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump     = 1'b1;
            ctrl.link     = 1'b1;
            ctrl.regwrite = 1'b1;
            dst           = REG_AW'(5'd31);
            legal_s       = ext_s;
         end
         OP_ADDI, OP_SLTI, OP_ORI: begin
            uses_rs       = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            dst           = rt;
            legal_s       = ext_s;
            if (opcode_s == OP_ORI) begin
               ctrl.aluop = ALU_OR;
               ctrl.extop = EXT_ZERO;
            end else begin
               ctrl.aluop = (opcode_s == OP_SLTI) ? ALU_SLT : ALU_ADD;
               ctrl.extop = EXT_SIGNED;
            end
         end
         default: legal_s = 1'b0;
      endcase
      if (!legal_s) begin
         ctrl    = illegal_bundle();
         dst     = {REG_AW{1'b0}};
         uses_rs = 1'b0;
         uses_rt = 1'b0;
      end else begin
         ctrl.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID instruction, carries controls through
// ID/EX, EX/MEM and MEM/WB, inserts load-use bubbles and counts them.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int EXT_ISA = 1,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   ctrl_pipe_if.slave bus
);
   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   ctrl_t             dec_ctrl_s;
   logic [REG_AW-1:0] dec_dst_s;
   logic [REG_AW-1:0] rs_s;
   logic [REG_AW-1:0] rt_s;
   logic              uses_rs_s;
   logic              uses_rt_s;
   logic              hazard_s;

   ctrl_t             ex_ctrl_r,  ex_ctrl_s;
   logic [REG_AW-1:0] ex_dst_r,   ex_dst_s;
   mem_ctrl_t         mem_ctrl_r, mem_ctrl_s;
   logic [REG_AW-1:0] mem_dst_r,  mem_dst_s;
   wb_ctrl_t          wb_ctrl_r,  wb_ctrl_s;
   logic [REG_AW-1:0] wb_dst_r,   wb_dst_s;
   logic [CNT_W-1:0]  cnt_r,      cnt_s;

   ctrl_decode #(
      .EXT_ISA (EXT_ISA),
      .REG_AW  (REG_AW)
   ) u_decode (
      .ins     (bus.ins_id),
      .ctrl    (dec_ctrl_s),
      .dst     (dec_dst_s),
      .rs      (rs_s),
      .rt      (rt_s),
      .uses_rs (uses_rs_s),
      .uses_rt (uses_rt_s)
   );

   // Load in EX writing a register the ID instruction reads; $0 never conflicts
   always_comb begin
      hazard_s = ex_ctrl_r.memread & (ex_dst_r != REG_ZERO) &
                 (((ex_dst_r == rs_s) & uses_rs_s) | ((ex_dst_r == rt_s) & uses_rt_s));
   end

   assign bus.id_stall = bus.ext_stall | (hazard_s & ~bus.flush);

   // Next-state for every pipeline stage and the bubble counter
   always_comb begin
      ex_ctrl_s  = ex_ctrl_r;
      ex_dst_s   = ex_dst_r;
      mem_ctrl_s = mem_ctrl_r;
      mem_dst_s  = mem_dst_r;
      wb_ctrl_s  = wb_ctrl_r;
      wb_dst_s   = wb_dst_r;
      cnt_s      = cnt_r;
      if (bus.ext_stall) begin
         cnt_s = cnt_r;
      end else begin
         mem_ctrl_s = '{memread:  ex_ctrl_r.memread,  memwrite: ex_ctrl_r.memwrite,
                        regwrite: ex_ctrl_r.regwrite, memtoreg: ex_ctrl_r.memtoreg,
                        link:     ex_ctrl_r.link};
         mem_dst_s  = ex_dst_r;
         wb_ctrl_s  = '{regwrite: mem_ctrl_r.regwrite, memtoreg: mem_ctrl_r.memtoreg,
                        link:     mem_ctrl_r.link};
         wb_dst_s   = mem_dst_r;
         ex_ctrl_s  = BUBBLE;
         ex_dst_s   = REG_ZERO;
         if (bus.flush) begin
            cnt_s = cnt_r;
         end else if (hazard_s) begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
         end else if (bus.ins_valid) begin
            ex_ctrl_s = dec_ctrl_s;
            ex_dst_s  = dec_dst_s;
         end else begin
            cnt_s = cnt_r;
         end
      end
   end

   // Stage registers, all cleared to bubble on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl_r  <= BUBBLE;
         ex_dst_r   <= REG_ZERO;
         mem_ctrl_r <= '0;
         mem_dst_r  <= REG_ZERO;
         wb_ctrl_r  <= '0;
         wb_dst_r   <= REG_ZERO;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         ex_ctrl_r  <= ex_ctrl_s;
         ex_dst_r   <= ex_dst_s;
         mem_ctrl_r <= mem_ctrl_s;
         mem_dst_r  <= mem_dst_s;
         wb_ctrl_r  <= wb_ctrl_s;
         wb_dst_r   <= wb_dst_s;
         cnt_r      <= cnt_s;
      end
   end

   assign bus.ex_aluop     = ex_ctrl_r.aluop;
   assign bus.ex_alusrc    = ex_ctrl_r.alusrc;
   assign bus.ex_extop     = ex_ctrl_r.extop;
   assign bus.ex_branch    = ex_ctrl_r.branch;
   assign bus.ex_jump      = ex_ctrl_r.jump;
   assign bus.ex_illegal   = ex_ctrl_r.illegal;
   assign bus.ex_dst       = ex_dst_r;
   assign bus.mem_memwrite = mem_ctrl_r.memwrite;
   assign bus.mem_memread  = mem_ctrl_r.memread;
   assign bus.mem_dst      = mem_dst_r;
   assign bus.wb_regwrite  = wb_ctrl_r.regwrite;
   assign bus.wb_memtoreg  = wb_ctrl_r.memtoreg;
   assign bus.wb_link      = wb_ctrl_r.link;
   assign bus.wb_dst       = wb_dst_r;
   assign bus.bubble_cnt   = cnt_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: u1 is the full ISA with a 16-bit counter,
// u2 is the base ISA with a 2-bit counter for saturation and illegal checks.
module tb_ctrl_pipe;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   exp_cnt1;

   ctrl_pipe_if #(.REG_AW(5), .CNT_W(16)) b1 ();
   ctrl_pipe_if #(.REG_AW(5), .CNT_W(2))  b2 ();

   ctrl_pipe #(.EXT_ISA(1), .REG_AW(5), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   ctrl_pipe #(.EXT_ISA(0), .REG_AW(5), .CNT_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic [31:0] ins, input logic valid);
      b1.ins_id    = ins;
      b1.ins_valid = valid;
   endtask

   task automatic drive2(input logic [31:0] ins, input logic valid);
      b2.ins_id    = ins;
      b2.ins_valid = valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive1(32'd0, 1'b0); b1.flush = 1'b0; b1.ext_stall = 1'b0;
      drive2(32'd0, 1'b0); b2.flush = 1'b0; b2.ext_stall = 1'b0;
      #2;
      total++; if ({b1.ex_aluop, b1.ex_alusrc, b1.ex_extop, b1.ex_branch, b1.ex_jump, b1.ex_illegal} !== 10'd0) begin bad++; $display("FAIL reset_ex_ctrl got=%h exp=0", {b1.ex_aluop, b1.ex_alusrc, b1.ex_extop, b1.ex_branch, b1.ex_jump, b1.ex_illegal}); end
      total++; if ({b1.ex_dst, b1.mem_dst, b1.wb_dst} !== 15'd0) begin bad++; $display("FAIL reset_dst got=%h exp=0", {b1.ex_dst, b1.mem_dst, b1.wb_dst}); end
      total++; if ({b1.mem_memwrite, b1.mem_memread, b1.wb_regwrite, b1.wb_memtoreg, b1.wb_link} !== 5'd0) begin bad++; $display("FAIL reset_mem_wb got=%b exp=0", {b1.mem_memwrite, b1.mem_memread, b1.wb_regwrite, b1.wb_memtoreg, b1.wb_link}); end
      total++; if (b1.bubble_cnt !== 16'd0 || b2.bubble_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", b1.bubble_cnt, b2.bubble_cnt); end
      total++; if (b1.id_stall !== 1'b0) begin bad++; $display("FAIL reset_id_stall got=%b exp=0", b1.id_stall); end
      tick(); tick();
      rst_n = 1'b1;
      exp_cnt1 = 0;
      tick();
   endtask

   task automatic test_add_latency();
      drive1(r_ins(1, 2, 3, 6'h20), 1'b1);
      tick();
      drive1(32'd0, 1'b0);
      total++; if (b1.ex_aluop !== 3'd0 || b1.ex_dst !== 5'd3) begin bad++; $display("FAIL add_ex got=aluop%0d dst%0d exp=aluop0 dst3", b1.ex_aluop, b1.ex_dst); end
      tick();
      total++; if (b1.mem_dst !== 5'd3 || b1.ex_dst !== 5'd0) begin bad++; $display("FAIL add_mem got=mem%0d ex%0d exp=mem3 ex0", b1.mem_dst, b1.ex_dst); end
      tick();
      total++; if (b1.wb_regwrite !== 1'b1 || b1.wb_dst !== 5'd3 || b1.wb_memtoreg !== 1'b0) begin bad++; $display("FAIL add_wb got=rw%b dst%0d m2r%b exp=rw1 dst3 m2r0", b1.wb_regwrite, b1.wb_dst, b1.wb_memtoreg); end
      tick();
   endtask

   task automatic test_decode();
      logic [31:0] ins_t [9];
      logic [2:0]  alu_t [9];
      logic        src_t [9];
      logic [1:0]  ext_t [9];
      logic [4:0]  dst_t [9];
      ins_t[0] = r_ins(1, 2, 3, 6'h20);          alu_t[0] = 3'd0; src_t[0] = 1'b0; ext_t[0] = 2'd0; dst_t[0] = 5'd3;
      ins_t[1] = r_ins(1, 2, 4, 6'h22);          alu_t[1] = 3'd1; src_t[1] = 1'b0; ext_t[1] = 2'd0; dst_t[1] = 5'd4;
      ins_t[2] = r_ins(1, 2, 5, 6'h24);          alu_t[2] = 3'd2; src_t[2] = 1'b0; ext_t[2] = 2'd0; dst_t[2] = 5'd5;
      ins_t[3] = r_ins(1, 2, 6, 6'h25);          alu_t[3] = 3'd3; src_t[3] = 1'b0; ext_t[3] = 2'd0; dst_t[3] = 5'd6;
      ins_t[4] = r_ins(1, 2, 7, 6'h27);          alu_t[4] = 3'd4; src_t[4] = 1'b0; ext_t[4] = 2'd0; dst_t[4] = 5'd7;
      ins_t[5] = r_ins(1, 2, 8, 6'h2A);          alu_t[5] = 3'd5; src_t[5] = 1'b0; ext_t[5] = 2'd0; dst_t[5] = 5'd8;
      ins_t[6] = i_ins(6'h08, 1, 9, 16'hFFFF);   alu_t[6] = 3'd0; src_t[6] = 1'b1; ext_t[6] = 2'd1; dst_t[6] = 5'd9;
      ins_t[7] = i_ins(6'h0D, 1, 10, 16'h00FF);  alu_t[7] = 3'd3; src_t[7] = 1'b1; ext_t[7] = 2'd0; dst_t[7] = 5'd10;
      ins_t[8] = i_ins(6'h2B, 1, 12, 16'h0004);  alu_t[8] = 3'd0; src_t[8] = 1'b1; ext_t[8] = 2'd1; dst_t[8] = 5'd0;
      for (int i = 0; i < 9; i++) begin
         drive1(ins_t[i], 1'b1);
         tick();
         total++; if (b1.ex_aluop !== alu_t[i] || b1.ex_alusrc !== src_t[i] || b1.ex_extop !== ext_t[i] || b1.ex_dst !== dst_t[i] || b1.ex_illegal !== 1'b0)
            begin bad++; $display("FAIL decode_%0d got=alu%0d src%b ext%0d dst%0d ill%b exp=alu%0d src%b ext%0d dst%0d ill0", i, b1.ex_aluop, b1.ex_alusrc, b1.ex_extop, b1.ex_dst, b1.ex_illegal, alu_t[i], src_t[i], ext_t[i], dst_t[i]); end
      end
      drive1(i_ins(6'h0A, 1, 11, 16'h8000), 1'b1);
      tick();
      total++; if (b1.ex_aluop !== 3'd5 || b1.ex_extop !== 2'd1 || b1.ex_dst !== 5'd11) begin bad++; $display("FAIL decode_slti got=alu%0d ext%0d dst%0d exp=alu5 ext1 dst11", b1.ex_aluop, b1.ex_extop, b1.ex_dst); end
      total++; if (b1.mem_memwrite !== 1'b1 || b1.mem_dst !== 5'd0) begin bad++; $display("FAIL sw_mem got=mw%b dst%0d exp=mw1 dst0", b1.mem_memwrite, b1.mem_dst); end
      drive1(i_ins(6'h04, 1, 2, 16'h0010), 1'b1);
      tick();
      total++; if (b1.ex_branch !== 2'd1 || b1.ex_aluop !== 3'd1 || b1.ex_dst !== 5'd0) begin bad++; $display("FAIL beq got=br%0d alu%0d dst%0d exp=br1 alu1 dst0", b1.ex_branch, b1.ex_aluop, b1.ex_dst); end
      drive1(i_ins(6'h05, 1, 2, 16'h0010), 1'b1);
      tick();
      total++; if (b1.ex_branch !== 2'd2 || b1.ex_aluop !== 3'd1) begin bad++; $display("FAIL bne got=br%0d alu%0d exp=br2 alu1", b1.ex_branch, b1.ex_aluop); end
      drive1({6'h02, 26'h0000100}, 1'b1);
      tick();
      total++; if (b1.ex_jump !== 1'b1 || b1.ex_dst !== 5'd0 || b1.ex_branch !== 2'd0) begin bad++; $display("FAIL j got=jmp%b dst%0d br%0d exp=jmp1 dst0 br0", b1.ex_jump, b1.ex_dst, b1.ex_branch); end
      drive1(r_ins(1, 2, 13, 6'h01), 1'b1);
      tick();
      total++; if (b1.ex_illegal !== 1'b1 || b1.ex_dst !== 5'd0) begin bad++; $display("FAIL bad_funct got=ill%b dst%0d exp=ill1 dst0", b1.ex_illegal, b1.ex_dst); end
      drive1(i_ins(6'h23, 1, 14, 16'h0000), 1'b0);
      tick();
      total++; if (b1.ex_illegal !== 1'b0 || b1.ex_dst !== 5'd0 || b1.ex_alusrc !== 1'b0) begin bad++; $display("FAIL invalid_slot got=ill%b dst%0d src%b exp=ill0 dst0 src0", b1.ex_illegal, b1.ex_dst, b1.ex_alusrc); end
      total++; if (b1.wb_regwrite !== 1'b0 || b1.mem_memwrite !== 1'b0) begin bad++; $display("FAIL illegal_no_write got=wbrw%b memw%b exp=0 0", b1.wb_regwrite, b1.mem_memwrite); end
      drive1(32'd0, 1'b0);
      tick(); tick();
   endtask

   task automatic test_load_use();
      drive1(i_ins(6'h23, 1, 5, 16'h0000), 1'b1);
      tick();
      drive1(r_ins(5, 2, 6, 6'h20), 1'b1);
      #1;
      total++; if (b1.id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", b1.id_stall); end
      tick();
      exp_cnt1 = exp_cnt1 + 1;
      total++; if (b1.ex_dst !== 5'd0 || b1.ex_alusrc !== 1'b0 || b1.bubble_cnt !== 16'(exp_cnt1)) begin bad++; $display("FAIL lu_bubble got=dst%0d src%b cnt%0d exp=dst0 src0 cnt%0d", b1.ex_dst, b1.ex_alusrc, b1.bubble_cnt, exp_cnt1); end
      total++; if (b1.mem_memread !== 1'b1 || b1.mem_dst !== 5'd5 || b1.id_stall !== 1'b0) begin bad++; $display("FAIL lu_after got=mr%b dst%0d stall%b exp=mr1 dst5 stall0", b1.mem_memread, b1.mem_dst, b1.id_stall); end
      tick();
      drive1(32'd0, 1'b0);
      total++; if (b1.ex_dst !== 5'd6 || b1.wb_memtoreg !== 1'b1 || b1.wb_dst !== 5'd5) begin bad++; $display("FAIL lu_resume got=ex%0d m2r%b wb%0d exp=ex6 m2r1 wb5", b1.ex_dst, b1.wb_memtoreg, b1.wb_dst); end
      tick();
   endtask

   task automatic test_flush_hazard();
      drive1(i_ins(6'h23, 1, 5, 16'h0000), 1'b1);
      tick();
      drive1(r_ins(5, 2, 6, 6'h20), 1'b1);
      b1.flush = 1'b1;
      #1;
      total++; if (b1.id_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", b1.id_stall); end
      tick();
      b1.flush = 1'b0;
      drive1(32'd0, 1'b0);
      total++; if (b1.ex_dst !== 5'd0 || b1.ex_illegal !== 1'b0 || b1.bubble_cnt !== 16'(exp_cnt1)) begin bad++; $display("FAIL flush_bubble got=dst%0d ill%b cnt%0d exp=dst0 ill0 cnt%0d", b1.ex_dst, b1.ex_illegal, b1.bubble_cnt, exp_cnt1); end
      tick(); tick(); tick();
   endtask

   task automatic test_ext_stall();
      drive1(i_ins(6'h23, 1, 8, 16'h0004), 1'b1);
      tick();
      drive1(i_ins(6'h2B, 1, 9, 16'h0008), 1'b1);
      tick();
      drive1(r_ins(1, 2, 10, 6'h20), 1'b1);
      b1.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (b1.id_stall !== 1'b1) begin bad++; $display("FAIL stall_id_%0d got=%b exp=1", i, b1.id_stall); end
         tick();
         total++; if (b1.ex_dst !== 5'd0 || b1.ex_alusrc !== 1'b1 || b1.ex_extop !== 2'd1 || b1.mem_memread !== 1'b1 || b1.mem_dst !== 5'd8 || b1.wb_regwrite !== 1'b0 || b1.bubble_cnt !== 16'(exp_cnt1))
            begin bad++; $display("FAIL stall_hold_%0d got=exdst%0d src%b mr%b memdst%0d wbrw%b cnt%0d exp=0 1 1 8 0 %0d", i, b1.ex_dst, b1.ex_alusrc, b1.mem_memread, b1.mem_dst, b1.wb_regwrite, b1.bubble_cnt, exp_cnt1); end
      end
      b1.ext_stall = 1'b0;
      tick();
      drive1(32'd0, 1'b0);
      total++; if (b1.ex_dst !== 5'd10 || b1.mem_memwrite !== 1'b1 || b1.wb_dst !== 5'd8 || b1.wb_memtoreg !== 1'b1) begin bad++; $display("FAIL stall_resume got=ex%0d mw%b wb%0d m2r%b exp=ex10 mw1 wb8 m2r1", b1.ex_dst, b1.mem_memwrite, b1.wb_dst, b1.wb_memtoreg); end
      tick();
      total++; if (b1.mem_dst !== 5'd10 || b1.wb_regwrite !== 1'b0) begin bad++; $display("FAIL stall_drain got=mem%0d wbrw%b exp=mem10 wbrw0", b1.mem_dst, b1.wb_regwrite); end
      tick(); tick();
   endtask

   task automatic test_ext_isa();
      drive2(i_ins(6'h08, 1, 4, 16'h0005), 1'b1);
      tick();
      drive2(32'd0, 1'b0);
      total++; if (b2.ex_illegal !== 1'b1 || b2.ex_dst !== 5'd0 || b2.ex_alusrc !== 1'b0) begin bad++; $display("FAIL base_addi got=ill%b dst%0d src%b exp=ill1 dst0 src0", b2.ex_illegal, b2.ex_dst, b2.ex_alusrc); end
      tick();
      total++; if (b2.ex_illegal !== 1'b0 || b2.mem_memwrite !== 1'b0 || b2.mem_dst !== 5'd0) begin bad++; $display("FAIL base_ill_once got=ill%b mw%b dst%0d exp=0 0 0", b2.ex_illegal, b2.mem_memwrite, b2.mem_dst); end
      tick();
      total++; if (b2.wb_regwrite !== 1'b0) begin bad++; $display("FAIL base_ill_wb got=%b exp=0", b2.wb_regwrite); end
      drive1({6'h03, 26'h0000040}, 1'b1);
      tick();
      drive1(32'd0, 1'b0);
      total++; if (b1.ex_jump !== 1'b1 || b1.ex_dst !== 5'd31) begin bad++; $display("FAIL jal_ex got=jmp%b dst%0d exp=jmp1 dst31", b1.ex_jump, b1.ex_dst); end
      tick(); tick();
      total++; if (b1.wb_link !== 1'b1 || b1.wb_dst !== 5'd31 || b1.wb_regwrite !== 1'b1) begin bad++; $display("FAIL jal_wb got=link%b dst%0d rw%b exp=link1 dst31 rw1", b1.wb_link, b1.wb_dst, b1.wb_regwrite); end
      tick();
   endtask

   task automatic test_saturate();
      int exp2;
      exp2 = 0;
      for (int i = 0; i < 5; i++) begin
         drive2(i_ins(6'h23, 1, 5, 16'h0000), 1'b1);
         tick();
         drive2(r_ins(5, 2, 6, 6'h20), 1'b1);
         tick();
         drive2(32'd0, 1'b0);
         exp2 = (exp2 == 3) ? 3 : exp2 + 1;
         total++; if (b2.bubble_cnt !== 2'(exp2)) begin bad++; $display("FAIL sat_%0d got=%0d exp=%0d", i, b2.bubble_cnt, exp2); end
         tick();
      end
      drive2(i_ins(6'h23, 1, 0, 16'h0000), 1'b1);
      tick();
      drive2(r_ins(0, 0, 6, 6'h20), 1'b1);
      #1;
      total++; if (b2.id_stall !== 1'b0) begin bad++; $display("FAIL r0_no_stall got=%b exp=0", b2.id_stall); end
      tick();
      drive2(32'd0, 1'b0);
      total++; if (b2.ex_dst !== 5'd6 || b2.bubble_cnt !== 2'd3) begin bad++; $display("FAIL r0_flow got=dst%0d cnt%0d exp=dst6 cnt3", b2.ex_dst, b2.bubble_cnt); end
      tick();
   endtask

   task automatic test_reset_mid();
      drive1(i_ins(6'h23, 1, 7, 16'h0000), 1'b1);
      tick();
      drive1(32'd0, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (b1.ex_dst !== 5'd0 || b1.mem_dst !== 5'd0 || b1.mem_memread !== 1'b0 || b1.bubble_cnt !== 16'd0 || b2.bubble_cnt !== 2'd0)
         begin bad++; $display("FAIL mid_reset got=ex%0d mem%0d mr%b cnt%0d/%0d exp=0", b1.ex_dst, b1.mem_dst, b1.mem_memread, b1.bubble_cnt, b2.bubble_cnt); end
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (b1.wb_dst !== 5'd0 || b1.wb_memtoreg !== 1'b0) begin bad++; $display("FAIL mid_reset_wb got=dst%0d m2r%b exp=0 0", b1.wb_dst, b1.wb_memtoreg); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_cnt1 = 0;
      test_reset();
      test_add_latency();
      test_decode();
      test_load_use();
      test_flush_hazard();
      test_ext_stall();
      test_ext_isa();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
